// File: rtl/k12a_pkg.sv
// Shared k12a types: ACU operand selects, requester op codes and the ACU
// sequencer state encoding, plus the op-to-operand decode helpers.
package k12a_pkg;

  typedef enum logic [1:0] {
    PC_OP_NEXT = 2'd0,
    PC_OP_SKIP = 2'd1,
    PC_OP_PREV = 2'd2,
    PC_OP_REL  = 2'd3
  } pc_op_t;

  typedef enum logic {
    CD_OP_INC = 1'b0,
    CD_OP_DEC = 1'b1
  } cd_op_t;

  typedef enum logic {
    ACU_IN1_PC = 1'b0,
    ACU_IN1_CD = 1'b1
  } acu_input1_sel_t;

  typedef enum logic [1:0] {
    ACU_IN2_ONE        = 2'd0,
    ACU_IN2_TWO        = 2'd1,
    ACU_IN2_MINUS_ONE  = 2'd2,
    ACU_IN2_REL_OFFSET = 2'd3
  } acu_input2_sel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    DRIVE    = 2'd2,
    COMMIT   = 2'd3
  } acu_seq_state_t;

  function automatic acu_input2_sel_t pc_op_input2(input pc_op_t op);
    case (op)
      PC_OP_NEXT: return ACU_IN2_ONE;
      PC_OP_SKIP: return ACU_IN2_TWO;
      PC_OP_PREV: return ACU_IN2_MINUS_ONE;
      default:    return ACU_IN2_REL_OFFSET;
    endcase
  endfunction

  // Decrement is an add of FFFF; the ACU wraps modulo 2^16.
  function automatic acu_input2_sel_t cd_op_input2(input cd_op_t op);
    return (op == CD_OP_DEC) ? ACU_IN2_MINUS_ONE : ACU_IN2_ONE;
  endfunction

endpackage

// File: rtl/k12a_acu_arbiter.sv
// Two-way PC/CD arbiter: round-robin on "port not served last", or fixed
// PC priority. With no valid request the grant rests on the PC port.
module k12a_acu_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pc_valid,
  input  logic cd_valid,
  input  logic accept,
  output logic grant_cd
);

  logic prefer_cd_reg;

  always_comb begin
    grant_cd = 1'b0;
    if (pc_valid && cd_valid) begin
      grant_cd = ROUND_ROBIN && prefer_cd_reg;
    end else if (cd_valid) begin
      grant_cd = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prefer_cd_reg <= 1'b0;
    end else if (accept && ROUND_ROBIN) begin
      prefer_cd_reg <= !grant_cd;
    end
  end

endmodule

// File: rtl/k12a_acu_sequencer.sv
// ACU controller: arbitrates PC/CD requests, then sequences each op through
// wait-for-bus, drive/settle and commit, issuing the destination load strobe.
module k12a_acu_sequencer
  import k12a_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          ROUND_ROBIN   = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_req_valid,
  input  pc_op_t          pc_req_op,
  output logic            pc_req_ready,
  output logic            pc_done,
  input  logic            cd_req_valid,
  input  cd_op_t          cd_req_op,
  output logic            cd_req_ready,
  output logic            cd_done,
  input  logic            bus_grant,
  output acu_input1_sel_t acu_input1_sel,
  output acu_input2_sel_t acu_input2_sel,
  output logic            acu_load,
  output logic            pc_load,
  output logic            cd_load,
  output logic            busy
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  acu_seq_state_t  state_reg, state_next;
  logic [2:0]      settle_cnt_reg, settle_cnt_next;
  logic            is_cd_reg, is_cd_next;
  acu_input1_sel_t sel1_reg, sel1_next;
  acu_input2_sel_t sel2_reg, sel2_next;
  logic            grant_cd;
  logic            accept_cd;
  logic            accept;

  k12a_acu_arbiter #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_arbiter (
    .clock   (clock),
    .reset   (reset),
    .pc_valid(pc_req_valid),
    .cd_valid(cd_req_valid),
    .accept  (accept),
    .grant_cd(grant_cd)
  );

  always_comb begin
    pc_req_ready = 1'b0;
    cd_req_ready = 1'b0;
    if (state_reg == IDLE && !reset) begin
      cd_req_ready = grant_cd;
      pc_req_ready = !grant_cd;
    end
  end

  assign accept_cd      = cd_req_valid && cd_req_ready;
  assign accept         = accept_cd || (pc_req_valid && pc_req_ready);
  assign busy           = (state_reg != IDLE);
  assign acu_input1_sel = sel1_reg;
  assign acu_input2_sel = sel2_reg;

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    is_cd_next      = is_cd_reg;
    sel1_next       = sel1_reg;
    sel2_next       = sel2_reg;
    acu_load        = 1'b0;
    pc_load         = 1'b0;
    cd_load         = 1'b0;
    pc_done         = 1'b0;
    cd_done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          is_cd_next      = accept_cd;
          settle_cnt_next = 3'd0;
          if (accept_cd) begin
            sel1_next = ACU_IN1_CD;
            sel2_next = cd_op_input2(cd_req_op);
          end else begin
            sel1_next = ACU_IN1_PC;
            sel2_next = pc_op_input2(pc_req_op);
          end
          state_next = bus_grant ? DRIVE : WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        if (bus_grant) begin
          state_next      = DRIVE;
          settle_cnt_next = 3'd0;
        end
      end
      DRIVE: begin
        acu_load = 1'b1;
        // Losing the bus mid-settle restarts the full settle window.
        if (!bus_grant) begin
          state_next      = WAIT_BUS;
          settle_cnt_next = 3'd0;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = COMMIT;
        end else begin
          settle_cnt_next = settle_cnt_reg + 3'd1;
        end
      end
      COMMIT: begin
        acu_load   = 1'b1;
        pc_load    = !is_cd_reg;
        cd_load    = is_cd_reg;
        pc_done    = !is_cd_reg;
        cd_done    = is_cd_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= 3'd0;
      is_cd_reg      <= 1'b0;
      sel1_reg       <= ACU_IN1_PC;
      sel2_reg       <= ACU_IN2_ONE;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      is_cd_reg      <= is_cd_next;
      sel1_reg       <= sel1_next;
      sel2_reg       <= sel2_next;
    end
  end

endmodule

// File: tb/tb_k12a_acu_sequencer.sv
// Bench for k12a_acu_sequencer: three configurations share one stimulus and are
// checked every cycle against a phase-count model, plus directed literal checks.
`timescale 1ns/1ps
module tb_k12a_acu_sequencer;
  import k12a_pkg::*;

  localparam int N = 3;
  localparam int S_TAB  [N] = '{1, 1, 3};
  localparam bit RR_TAB [N] = '{1'b1, 1'b0, 1'b1};

  logic   clock = 1'b0;
  logic   reset = 1'b1;
  logic   pc_req_valid = 1'b0;
  logic   cd_req_valid = 1'b0;
  logic   bus_grant = 1'b1;
  pc_op_t pc_req_op = PC_OP_NEXT;
  cd_op_t cd_req_op = CD_OP_INC;

  logic pc_rdy [N], cd_rdy [N], pc_done_w [N], cd_done_w [N];
  logic acu_w [N], pcl_w [N], cdl_w [N], busy_w [N];
  acu_input1_sel_t sel1_w [N];
  acu_input2_sel_t sel2_w [N];

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    k12a_acu_sequencer #(
      .SETTLE_CYCLES(S_TAB[gi]),
      .ROUND_ROBIN  (RR_TAB[gi])
    ) dut (
      .clock         (clock),
      .reset         (reset),
      .pc_req_valid  (pc_req_valid),
      .pc_req_op     (pc_req_op),
      .pc_req_ready  (pc_rdy[gi]),
      .pc_done       (pc_done_w[gi]),
      .cd_req_valid  (cd_req_valid),
      .cd_req_op     (cd_req_op),
      .cd_req_ready  (cd_rdy[gi]),
      .cd_done       (cd_done_w[gi]),
      .bus_grant     (bus_grant),
      .acu_input1_sel(sel1_w[gi]),
      .acu_input2_sel(sel2_w[gi]),
      .acu_load      (acu_w[gi]),
      .pc_load       (pcl_w[gi]),
      .cd_load       (cdl_w[gi]),
      .busy          (busy_w[gi])
    );
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[d%0d]: got %0h expected %0h", name, k, act, exp);
  endtask

  // Model: a transaction is "busy" with a phase count. Phase 0 = waiting for
  // the bus, 1..S = consecutive granted drive cycles, S+1 = commit cycle.
  bit              m_live;
  bit              m_busy    [N];
  bit              m_port_cd [N];
  bit              m_ptr_cd  [N];
  int              m_phase   [N];
  acu_input1_sel_t m_sel1    [N];
  acu_input2_sel_t m_sel2    [N];
  bit              m_cdw;
  bit              c_cdw;

  function automatic bit wins_cd(input int k);
    if (pc_req_valid && cd_req_valid) return RR_TAB[k] && m_ptr_cd[k];
    return cd_req_valid;
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        m_busy[k]   = 1'b0;
        m_phase[k]  = 0;
        m_ptr_cd[k] = 1'b0;
        m_sel1[k]   = ACU_IN1_PC;
        m_sel2[k]   = ACU_IN2_ONE;
      end else if (!m_busy[k]) begin
        m_cdw = wins_cd(k);
        if (m_cdw ? cd_req_valid : pc_req_valid) begin
          m_busy[k]    = 1'b1;
          m_port_cd[k] = m_cdw;
          m_phase[k]   = bus_grant ? 1 : 0;
          m_ptr_cd[k]  = !m_cdw;
          if (m_cdw) begin
            m_sel1[k] = ACU_IN1_CD;
            m_sel2[k] = (cd_req_op == CD_OP_DEC) ? ACU_IN2_MINUS_ONE : ACU_IN2_ONE;
          end else begin
            m_sel1[k] = ACU_IN1_PC;
            case (pc_req_op)
              PC_OP_NEXT: m_sel2[k] = ACU_IN2_ONE;
              PC_OP_SKIP: m_sel2[k] = ACU_IN2_TWO;
              PC_OP_PREV: m_sel2[k] = ACU_IN2_MINUS_ONE;
              default:    m_sel2[k] = ACU_IN2_REL_OFFSET;
            endcase
          end
        end
      end else if (m_phase[k] == S_TAB[k] + 1) begin
        m_busy[k] = 1'b0;
      end else if (m_phase[k] == 0) begin
        m_phase[k] = bus_grant ? 1 : 0;
      end else begin
        m_phase[k] = bus_grant ? m_phase[k] + 1 : 0;
      end
    end
    if (reset) m_live = 1'b1;
  end

  bit acc_log [N][$];
  int pcd_cnt [N];
  int cdd_cnt [N];
  int pcl_cnt [N];
  int cdl_cnt [N];

  always @(negedge clock) begin
    if (m_live) begin
      for (int k = 0; k < N; k++) begin
        bit commit, drv, idle_rdy;
        commit   = m_busy[k] && (m_phase[k] == S_TAB[k] + 1);
        drv      = m_busy[k] && (m_phase[k] >= 1);
        idle_rdy = !reset && !m_busy[k];
        c_cdw    = wins_cd(k);
        check("busy",     k, busy_w[k],    m_busy[k]);
        check("acu_load", k, acu_w[k],     drv);
        check("pc_load",  k, pcl_w[k],     commit && !m_port_cd[k]);
        check("cd_load",  k, cdl_w[k],     commit && m_port_cd[k]);
        check("pc_done",  k, pc_done_w[k], commit && !m_port_cd[k]);
        check("cd_done",  k, cd_done_w[k], commit && m_port_cd[k]);
        check("pc_ready", k, pc_rdy[k],    idle_rdy && !c_cdw);
        check("cd_ready", k, cd_rdy[k],    idle_rdy && c_cdw);
        check("sel1",     k, sel1_w[k],    m_sel1[k]);
        check("sel2",     k, sel2_w[k],    m_sel2[k]);
        if (!reset && pc_req_valid && pc_rdy[k] === 1'b1) acc_log[k].push_back(1'b0);
        if (!reset && cd_req_valid && cd_rdy[k] === 1'b1) acc_log[k].push_back(1'b1);
        if (pc_done_w[k] === 1'b1) pcd_cnt[k]++;
        if (cd_done_w[k] === 1'b1) cdd_cnt[k]++;
        if (pcl_w[k] === 1'b1) pcl_cnt[k]++;
        if (cdl_w[k] === 1'b1) cdl_cnt[k]++;
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < 60);
    check("idle_within_budget", 0, n < 60, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1, base2, ncd;

    // Reset state
    cycle();
    cycle();
    @(negedge clock);
    check("rst_busy",     0, busy_w[0], 0);
    check("rst_pc_ready", 0, pc_rdy[0], 0);
    check("rst_acu_load", 0, acu_w[0],  0);
    check("rst_sel1",     0, sel1_w[0], ACU_IN1_PC);
    check("rst_sel2",     0, sel2_w[0], ACU_IN2_ONE);
    cycle();
    reset = 1'b0;
    @(negedge clock);
    check("idle_pc_ready", 0, pc_rdy[0], 1);
    check("idle_cd_ready", 0, cd_rdy[0], 0);
    cycle();

    // Single PC_OP_NEXT with continuous grant
    base0 = pcd_cnt[0];
    pc_req_op = PC_OP_NEXT;
    pc_req_valid = 1'b1;
    bus_grant = 1'b1;
    cycle();
    pc_req_valid = 1'b0;
    @(negedge clock);
    check("s1_c1_acu",  0, acu_w[0],  1);
    check("s1_c1_pcl",  0, pcl_w[0],  0);
    check("s1_c1_sel2", 0, sel2_w[0], ACU_IN2_ONE);
    cycle();
    @(negedge clock);
    check("s1_c2_pcl",  0, pcl_w[0],     1);
    check("s1_c2_done", 0, pc_done_w[0], 1);
    check("s1_c2_acu",  0, acu_w[0],     1);
    cycle();
    @(negedge clock);
    check("s1_c3_ready", 0, pc_rdy[0], 1);
    check("s1_c3_busy",  0, busy_w[0], 0);
    wait_idle();
    check("s1_done_count", 0, pcd_cnt[0] - base0, 1);

    // Both ports valid every cycle; pointer starts on PC after reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    base0 = acc_log[0].size();
    base1 = acc_log[1].size();
    base2 = acc_log[2].size();
    cd_req_op = CD_OP_INC;
    pc_req_valid = 1'b1;
    cd_req_valid = 1'b1;
    repeat (16) cycle();
    pc_req_valid = 1'b0;
    cd_req_valid = 1'b0;
    wait_idle();
    check("s2_rr_count", 0, acc_log[0].size() - base0 >= 4, 1);
    for (int i = 0; i < 4; i++) check("s2_rr_order", 0, acc_log[0][base0 + i], i % 2);
    check("s2_rr_order_s3", 2, acc_log[2][base2],     0);
    check("s2_rr_order_s3", 2, acc_log[2][base2 + 1], 1);
    ncd = 0;
    for (int i = base1; i < acc_log[1].size(); i++) ncd += acc_log[1][i];
    check("s2_fixed_cd_grants", 1, ncd, 0);
    check("s2_fixed_count", 1, acc_log[1].size() - base1 >= 4, 1);

    // CD_OP_DEC with the bus withheld for three cycles
    bus_grant = 1'b0;
    cd_req_op = CD_OP_DEC;
    cd_req_valid = 1'b1;
    cycle();
    cd_req_valid = 1'b0;
    @(negedge clock);
    check("s3_w1_acu",  0, acu_w[0],  0);
    check("s3_w1_busy", 0, busy_w[0], 1);
    check("s3_w1_sel1", 0, sel1_w[0], ACU_IN1_CD);
    cycle();
    @(negedge clock);
    check("s3_w2_acu", 0, acu_w[0], 0);
    cycle();
    bus_grant = 1'b1;
    @(negedge clock);
    check("s3_w3_acu", 0, acu_w[0], 0);
    cycle();
    @(negedge clock);
    check("s3_drv_acu",  0, acu_w[0],  1);
    check("s3_drv_sel2", 0, sel2_w[0], ACU_IN2_MINUS_ONE);
    check("s3_drv_cdl",  0, cdl_w[0],  0);
    cycle();
    @(negedge clock);
    check("s3_cmt_cdl",  0, cdl_w[0],     1);
    check("s3_cmt_done", 0, cd_done_w[0], 1);
    check("s3_cmt_sel1", 0, sel1_w[0],    ACU_IN1_CD);
    wait_idle();

    // SETTLE_CYCLES=3: grant drops in the second drive cycle
    base2 = cdd_cnt[2];
    cd_req_op = CD_OP_INC;
    cd_req_valid = 1'b1;
    cycle();
    cd_req_valid = 1'b0;
    cycle();
    bus_grant = 1'b0;
    @(negedge clock);
    check("s4_drv2_acu", 2, acu_w[2], 1);
    cycle();
    bus_grant = 1'b1;
    @(negedge clock);
    check("s4_wait_acu",  2, acu_w[2],  0);
    check("s4_wait_busy", 2, busy_w[2], 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("s4_redrive_acu", 2, acu_w[2], 1);
      check("s4_redrive_cdl", 2, cdl_w[2], 0);
      cycle();
    end
    @(negedge clock);
    check("s4_cmt_cdl", 2, cdl_w[2], 1);
    wait_idle();
    check("s4_done_count", 2, cdd_cnt[2] - base2, 1);

    // PC_OP_REL
    base0 = pcl_cnt[0];
    base1 = cdl_cnt[0];
    pc_req_op = PC_OP_REL;
    pc_req_valid = 1'b1;
    cycle();
    pc_req_valid = 1'b0;
    @(negedge clock);
    check("s5_drv_sel1", 0, sel1_w[0], ACU_IN1_PC);
    check("s5_drv_sel2", 0, sel2_w[0], ACU_IN2_REL_OFFSET);
    cycle();
    @(negedge clock);
    check("s5_cmt_sel2", 0, sel2_w[0], ACU_IN2_REL_OFFSET);
    check("s5_cmt_pcl",  0, pcl_w[0],  1);
    wait_idle();
    check("s5_pcl_count", 0, pcl_cnt[0] - base0, 1);
    check("s5_cdl_count", 0, cdl_cnt[0] - base1, 0);

    // Reset during DRIVE aborts the op
    base0 = pcd_cnt[0];
    base2 = pcd_cnt[2];
    pc_req_op = PC_OP_NEXT;
    pc_req_valid = 1'b1;
    cycle();
    pc_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("s6_drv_acu", 2, acu_w[2], 1);
    cycle();
    reset = 1'b0;
    @(negedge clock);
    check("s6_abort_acu",  2, acu_w[2],  0);
    check("s6_abort_busy", 2, busy_w[2], 0);
    check("s6_abort_pcl",  0, pcl_w[0],  0);
    cycle();
    check("s6_no_done", 0, pcd_cnt[0] - base0, 0);
    check("s6_no_done", 2, pcd_cnt[2] - base2, 0);
    pc_req_valid = 1'b1;
    cycle();
    pc_req_valid = 1'b0;
    wait_idle();
    check("s6_reaccept_done", 0, pcd_cnt[0] - base0, 1);
    check("s6_reaccept_done", 2, pcd_cnt[2] - base2, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
